// File: rtl/axi_lite_arbiter.sv
// Two-master to one-slave AXI4-Lite arbiter with transaction-granular round-robin ownership.
// Optional watchdog: define AXI_ARB_TIMEOUT_EN to answer stalled transactions with SLVERR.

module axi_lite_arbiter #(
  parameter int ADDR_W  = 12,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 64
) (
  input  logic                  aclk,
  input  logic                  areset_n,
  input  logic [ADDR_W-1:0]     m0_araddr,
  input  logic                  m0_arvalid,
  output logic                  m0_arready,
  output logic [DATA_W-1:0]     m0_rdata,
  output logic [1:0]            m0_rresp,
  output logic                  m0_rvalid,
  input  logic                  m0_rready,
  input  logic [ADDR_W-1:0]     m0_awaddr,
  input  logic                  m0_awvalid,
  output logic                  m0_awready,
  input  logic [DATA_W-1:0]     m0_wdata,
  input  logic [DATA_W/8-1:0]   m0_wstrb,
  input  logic                  m0_wvalid,
  output logic                  m0_wready,
  output logic [1:0]            m0_bresp,
  output logic                  m0_bvalid,
  input  logic                  m0_bready,
  input  logic [ADDR_W-1:0]     m1_araddr,
  input  logic                  m1_arvalid,
  output logic                  m1_arready,
  output logic [DATA_W-1:0]     m1_rdata,
  output logic [1:0]            m1_rresp,
  output logic                  m1_rvalid,
  input  logic                  m1_rready,
  input  logic [ADDR_W-1:0]     m1_awaddr,
  input  logic                  m1_awvalid,
  output logic                  m1_awready,
  input  logic [DATA_W-1:0]     m1_wdata,
  input  logic [DATA_W/8-1:0]   m1_wstrb,
  input  logic                  m1_wvalid,
  output logic                  m1_wready,
  output logic [1:0]            m1_bresp,
  output logic                  m1_bvalid,
  input  logic                  m1_bready,
  output logic [ADDR_W-1:0]     s_araddr,
  output logic                  s_arvalid,
  input  logic                  s_arready,
  input  logic [DATA_W-1:0]     s_rdata,
  input  logic [1:0]            s_rresp,
  input  logic                  s_rvalid,
  output logic                  s_rready,
  output logic [ADDR_W-1:0]     s_awaddr,
  output logic                  s_awvalid,
  input  logic                  s_awready,
  output logic [DATA_W-1:0]     s_wdata,
  output logic [DATA_W/8-1:0]   s_wstrb,
  output logic                  s_wvalid,
  input  logic                  s_wready,
  input  logic [1:0]            s_bresp,
  input  logic                  s_bvalid,
  output logic                  s_bready,
  output logic [1:0]            grant
);

`ifdef AXI_ARB_TIMEOUT_EN
  typedef enum logic [2:0] {IDLE, RD, WR, RD_ERR, WR_ERR} state_t;
`else
  typedef enum logic [1:0] {IDLE, RD, WR} state_t;
`endif

  state_t r_state, w_state_next;
  logic   r_owner, w_owner_next;
  logic   r_prio,  w_prio_next;

  logic w_req0, w_req1, w_pick;
  logic w_in_rd, w_in_wr, w_in_rderr, w_in_wrerr;

  // Owner-selected master request signals
  logic [ADDR_W-1:0]   w_own_araddr, w_own_awaddr;
  logic [DATA_W-1:0]   w_own_wdata;
  logic [DATA_W/8-1:0] w_own_wstrb;
  logic w_own_arvalid, w_own_rready, w_own_awvalid, w_own_wvalid, w_own_bready;

  // Responses destined for whichever master currently owns the slave
  logic [DATA_W-1:0] w_rsp_rdata;
  logic [1:0]        w_rsp_rresp, w_rsp_bresp;
  logic w_rsp_arready, w_rsp_rvalid, w_rsp_awready, w_rsp_wready, w_rsp_bvalid;

  assign w_req0 = m0_arvalid | m0_awvalid;
  assign w_req1 = m1_arvalid | m1_awvalid;
  assign w_pick = (w_req0 & w_req1) ? r_prio : w_req1;

  assign w_in_rd = (r_state == RD);
  assign w_in_wr = (r_state == WR);

`ifdef AXI_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] r_cnt;

  assign w_in_rderr = (r_state == RD_ERR);
  assign w_in_wrerr = (r_state == WR_ERR);

  // Counts cycles spent in RD/WR; it is zero on entry because it holds zero elsewhere
  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      r_cnt <= '0;
    end else if (w_in_rd || w_in_wr) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end else begin
      r_cnt <= '0;
    end
  end
`else
  logic w_unused_timeout;

  assign w_in_rderr       = 1'b0;
  assign w_in_wrerr       = 1'b0;
  assign w_unused_timeout = (TIMEOUT != 0);
`endif

  assign w_own_araddr  = r_owner ? m1_araddr  : m0_araddr;
  assign w_own_arvalid = r_owner ? m1_arvalid : m0_arvalid;
  assign w_own_rready  = r_owner ? m1_rready  : m0_rready;
  assign w_own_awaddr  = r_owner ? m1_awaddr  : m0_awaddr;
  assign w_own_awvalid = r_owner ? m1_awvalid : m0_awvalid;
  assign w_own_wdata   = r_owner ? m1_wdata   : m0_wdata;
  assign w_own_wstrb   = r_owner ? m1_wstrb   : m0_wstrb;
  assign w_own_wvalid  = r_owner ? m1_wvalid  : m0_wvalid;
  assign w_own_bready  = r_owner ? m1_bready  : m0_bready;

  assign s_araddr  = w_in_rd ? w_own_araddr : '0;
  assign s_arvalid = w_in_rd & w_own_arvalid;
  assign s_rready  = w_in_rd & w_own_rready;
  assign s_awaddr  = w_in_wr ? w_own_awaddr : '0;
  assign s_awvalid = w_in_wr & w_own_awvalid;
  assign s_wdata   = w_in_wr ? w_own_wdata : '0;
  assign s_wstrb   = w_in_wr ? w_own_wstrb : '0;
  assign s_wvalid  = w_in_wr & w_own_wvalid;
  assign s_bready  = w_in_wr & w_own_bready;

  // Error states answer the owner directly with SLVERR and zero data
  assign w_rsp_arready = w_in_rd & s_arready;
  assign w_rsp_rvalid  = (w_in_rd & s_rvalid) | w_in_rderr;
  assign w_rsp_rdata   = w_in_rd ? s_rdata : '0;
  assign w_rsp_rresp   = w_in_rd ? s_rresp : (w_in_rderr ? 2'b10 : 2'b00);
  assign w_rsp_awready = w_in_wr & s_awready;
  assign w_rsp_wready  = w_in_wr & s_wready;
  assign w_rsp_bvalid  = (w_in_wr & s_bvalid) | w_in_wrerr;
  assign w_rsp_bresp   = w_in_wr ? s_bresp : (w_in_wrerr ? 2'b10 : 2'b00);

  assign m0_arready = ~r_owner & w_rsp_arready;
  assign m0_rvalid  = ~r_owner & w_rsp_rvalid;
  assign m0_rdata   = r_owner ? '0 : w_rsp_rdata;
  assign m0_rresp   = r_owner ? 2'b00 : w_rsp_rresp;
  assign m0_awready = ~r_owner & w_rsp_awready;
  assign m0_wready  = ~r_owner & w_rsp_wready;
  assign m0_bvalid  = ~r_owner & w_rsp_bvalid;
  assign m0_bresp   = r_owner ? 2'b00 : w_rsp_bresp;

  assign m1_arready = r_owner & w_rsp_arready;
  assign m1_rvalid  = r_owner & w_rsp_rvalid;
  assign m1_rdata   = r_owner ? w_rsp_rdata : '0;
  assign m1_rresp   = r_owner ? w_rsp_rresp : 2'b00;
  assign m1_awready = r_owner & w_rsp_awready;
  assign m1_wready  = r_owner & w_rsp_wready;
  assign m1_bvalid  = r_owner & w_rsp_bvalid;
  assign m1_bresp   = r_owner ? w_rsp_bresp : 2'b00;

  assign grant = (r_state == IDLE) ? 2'b00 : {r_owner, ~r_owner};

  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      r_state <= IDLE;
      r_owner <= 1'b0;
      r_prio  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_owner <= w_owner_next;
      r_prio  <= w_prio_next;
    end
  end

  // A read wins when the new owner presents both arvalid and awvalid
  always_comb begin
    w_state_next = r_state;
    w_owner_next = r_owner;
    w_prio_next  = r_prio;
    case (r_state)
      IDLE: begin
        if (w_req0 | w_req1) begin
          w_owner_next = w_pick;
          w_state_next = (w_pick ? m1_arvalid : m0_arvalid) ? RD : WR;
        end
      end
      RD: begin
        if (s_rvalid & s_rready) begin
          w_state_next = IDLE;
          w_prio_next  = ~r_owner;
        end
`ifdef AXI_ARB_TIMEOUT_EN
        else if (r_cnt == CNT_LAST) begin
          w_state_next = RD_ERR;
        end
`endif
      end
      WR: begin
        if (s_bvalid & s_bready) begin
          w_state_next = IDLE;
          w_prio_next  = ~r_owner;
        end
`ifdef AXI_ARB_TIMEOUT_EN
        else if (r_cnt == CNT_LAST) begin
          w_state_next = WR_ERR;
        end
`endif
      end
`ifdef AXI_ARB_TIMEOUT_EN
      RD_ERR: begin
        if (w_own_rready) begin
          w_state_next = IDLE;
          w_prio_next  = ~r_owner;
        end
      end
      WR_ERR: begin
        if (w_own_bready) begin
          w_state_next = IDLE;
          w_prio_next  = ~r_owner;
        end
      end
`endif
      default: w_state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_axi_lite_arbiter.sv
// Directed bench for axi_lite_arbiter: two table-driven master models, a reactive slave model,
// and a transaction log checked against hand-computed order, timing and data.

module tb_axi_lite_arbiter;
  localparam int AW = 12;
  localparam int DW = 32;

  logic aclk = 1'b0;
  logic areset_n = 1'b0;
  always #5 aclk = ~aclk;

  logic [AW-1:0] m_araddr [2];
  logic [AW-1:0] m_awaddr [2];
  logic [DW-1:0] m_wdata  [2];
  logic [3:0]    m_wstrb  [2];
  logic          m_arvalid[2], m_rready[2], m_awvalid[2], m_wvalid[2], m_bready[2];
  logic          m_arready[2], m_rvalid[2], m_awready[2], m_wready[2], m_bvalid[2];
  logic [DW-1:0] m_rdata  [2];
  logic [1:0]    m_rresp  [2];
  logic [1:0]    m_bresp  [2];

  logic [AW-1:0] s_araddr, s_awaddr;
  logic [DW-1:0] s_rdata, s_wdata;
  logic [3:0]    s_wstrb;
  logic [1:0]    s_rresp, s_bresp, grant;
  logic s_arvalid, s_arready, s_rvalid, s_rready;
  logic s_awvalid, s_awready, s_wvalid, s_wready, s_bvalid, s_bready;

  axi_lite_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(8)) dut (
    .aclk(aclk), .areset_n(areset_n),
    .m0_araddr(m_araddr[0]), .m0_arvalid(m_arvalid[0]), .m0_arready(m_arready[0]),
    .m0_rdata(m_rdata[0]), .m0_rresp(m_rresp[0]), .m0_rvalid(m_rvalid[0]), .m0_rready(m_rready[0]),
    .m0_awaddr(m_awaddr[0]), .m0_awvalid(m_awvalid[0]), .m0_awready(m_awready[0]),
    .m0_wdata(m_wdata[0]), .m0_wstrb(m_wstrb[0]), .m0_wvalid(m_wvalid[0]), .m0_wready(m_wready[0]),
    .m0_bresp(m_bresp[0]), .m0_bvalid(m_bvalid[0]), .m0_bready(m_bready[0]),
    .m1_araddr(m_araddr[1]), .m1_arvalid(m_arvalid[1]), .m1_arready(m_arready[1]),
    .m1_rdata(m_rdata[1]), .m1_rresp(m_rresp[1]), .m1_rvalid(m_rvalid[1]), .m1_rready(m_rready[1]),
    .m1_awaddr(m_awaddr[1]), .m1_awvalid(m_awvalid[1]), .m1_awready(m_awready[1]),
    .m1_wdata(m_wdata[1]), .m1_wstrb(m_wstrb[1]), .m1_wvalid(m_wvalid[1]), .m1_wready(m_wready[1]),
    .m1_bresp(m_bresp[1]), .m1_bvalid(m_bvalid[1]), .m1_bready(m_bready[1]),
    .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
    .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
    .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
    .grant(grant)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  int cyc = 0;
  always @(posedge aclk) cyc <= cyc + 1;

  // Master command tables (written by the main sequence) and progress (written by the master model)
  logic [AW-1:0] rd_tab[2][16];
  logic [AW-1:0] wa_tab[2][16];
  logic [DW-1:0] wd_tab[2][16];
  int  n_rd[2], n_wr[2], rd_idx[2], wr_idx[2], b_cnt[2], r_cyc[2];
  logic rd_wait[2], aw_done[2], w_done[2];
  logic [DW-1:0] rdat_log[2][16];
  logic [1:0]    rresp_log[2][16];
  logic m_abort = 1'b0;

  always begin
    @(negedge aclk);
    for (int gi = 0; gi < 2; gi++) begin
      if (m_abort) begin
        rd_idx[gi] = n_rd[gi]; wr_idx[gi] = n_wr[gi];
        rd_wait[gi] = 1'b0; aw_done[gi] = 1'b0; w_done[gi] = 1'b0;
      end
      m_arvalid[gi] = (rd_idx[gi] < n_rd[gi]) && !rd_wait[gi];
      m_araddr[gi]  = m_arvalid[gi] ? rd_tab[gi][rd_idx[gi]] : '0;
      m_awvalid[gi] = (wr_idx[gi] < n_wr[gi]) && !aw_done[gi];
      m_awaddr[gi]  = m_awvalid[gi] ? wa_tab[gi][wr_idx[gi]] : '0;
      m_wvalid[gi]  = (wr_idx[gi] < n_wr[gi]) && !w_done[gi];
      m_wdata[gi]   = m_wvalid[gi] ? wd_tab[gi][wr_idx[gi]] : '0;
      m_wstrb[gi]   = m_wvalid[gi] ? 4'hF : 4'h0;
      m_rready[gi]  = 1'b1;
      m_bready[gi]  = 1'b1;
    end
    #1;
    for (int gi = 0; gi < 2; gi++) begin
      if (m_arvalid[gi] && m_arready[gi]) rd_wait[gi] = 1'b1;
      if (m_rvalid[gi] && m_rready[gi]) begin
        rdat_log[gi][rd_idx[gi]]  = m_rdata[gi];
        rresp_log[gi][rd_idx[gi]] = m_rresp[gi];
        r_cyc[gi] = cyc + 1;
        rd_wait[gi] = 1'b0;
        rd_idx[gi]++;
      end
      if (m_awvalid[gi] && m_awready[gi]) aw_done[gi] = 1'b1;
      if (m_wvalid[gi] && m_wready[gi]) w_done[gi] = 1'b1;
      if (m_bvalid[gi] && m_bready[gi]) begin
        aw_done[gi] = 1'b0; w_done[gi] = 1'b0;
        wr_idx[gi]++; b_cnt[gi]++;
      end
    end
  end

  // Slave model: logs every address handshake, answers after a programmable latency
  logic          sl_ar_en = 1'b1;
  int            sl_rlat = 1, sl_blat = 0, sl_rcnt = 0, sl_bcnt = 0;
  logic [DW-1:0] sl_rdata = '0;
  logic          sl_rd_got = 1'b0, sl_aw_got = 1'b0, sl_w_got = 1'b0;
  logic          lg_wr  [64];
  logic [AW-1:0] lg_addr[64];
  logic [DW-1:0] lg_data[64];
  int            lg_cyc [64];
  int            lg_n = 0;

  always begin
    @(negedge aclk);
    if (!areset_n) begin
      sl_rd_got = 1'b0; sl_aw_got = 1'b0; sl_w_got = 1'b0; sl_rcnt = 0; sl_bcnt = 0;
    end
    s_arready = areset_n && sl_ar_en && !sl_rd_got;
    s_rvalid  = sl_rd_got && (sl_rcnt == 0);
    s_rdata   = s_rvalid ? sl_rdata : '0;
    s_rresp   = 2'b00;
    s_awready = areset_n && !sl_aw_got;
    s_wready  = areset_n && !sl_w_got;
    s_bvalid  = sl_aw_got && sl_w_got && (sl_bcnt == 0);
    s_bresp   = 2'b00;
    #1;
    if (s_arvalid && s_arready) begin
      sl_rd_got = 1'b1; sl_rcnt = sl_rlat;
      lg_wr[lg_n] = 1'b0; lg_addr[lg_n] = s_araddr; lg_data[lg_n] = '0; lg_cyc[lg_n] = cyc + 1;
      $display("txn %0d READ  addr=%h cyc=%0d", lg_n, s_araddr, cyc + 1);
      lg_n++;
    end else if (sl_rd_got && sl_rcnt > 0) begin
      sl_rcnt--;
    end
    if (s_rvalid && s_rready) sl_rd_got = 1'b0;
    if (s_awvalid && s_awready) begin
      sl_aw_got = 1'b1; sl_bcnt = sl_blat;
      lg_wr[lg_n] = 1'b1; lg_addr[lg_n] = s_awaddr; lg_data[lg_n] = s_wdata; lg_cyc[lg_n] = cyc + 1;
      $display("txn %0d WRITE addr=%h data=%h cyc=%0d", lg_n, s_awaddr, s_wdata, cyc + 1);
      lg_n++;
    end else if (sl_aw_got && sl_w_got && sl_bcnt > 0) begin
      sl_bcnt--;
    end
    if (s_wvalid && s_wready) sl_w_got = 1'b1;
    if (s_bvalid && s_bready) begin
      sl_aw_got = 1'b0; sl_w_got = 1'b0;
    end
  end

  // Isolation monitor: a non-owner master and an idle slave port must see all-zero outputs
  int viol = 0;
  always begin
    @(negedge aclk);
    #2;
    for (int gi = 0; gi < 2; gi++) begin
      if (!grant[gi] && (m_arready[gi] || m_rvalid[gi] || m_awready[gi] || m_wready[gi] ||
          m_bvalid[gi] || (|m_rdata[gi]) || (|m_rresp[gi]) || (|m_bresp[gi])))
        viol++;
    end
    if (grant == 2'b00 && (s_arvalid || s_rready || s_awvalid || s_wvalid || s_bready ||
        (|s_araddr) || (|s_awaddr) || (|s_wdata) || (|s_wstrb) || m_arready[0] || m_arready[1]))
      viol++;
  end

  function automatic logic any_out();
    return (|grant) | (|s_araddr) | s_arvalid | s_rready | (|s_awaddr) | s_awvalid |
           (|s_wdata) | (|s_wstrb) | s_wvalid | s_bready |
           m_arready[0] | m_rvalid[0] | (|m_rdata[0]) | (|m_rresp[0]) | m_awready[0] | m_wready[0] |
           m_bvalid[0] | (|m_bresp[0]) |
           m_arready[1] | m_rvalid[1] | (|m_rdata[1]) | (|m_rresp[1]) | m_awready[1] | m_wready[1] |
           m_bvalid[1] | (|m_bresp[1]);
  endfunction

  task automatic push_rd(input int m, input logic [AW-1:0] a);
    rd_tab[m][n_rd[m]] = a;
    n_rd[m]++;
  endtask

  task automatic push_wr(input int m, input logic [AW-1:0] a, input logic [DW-1:0] d);
    wa_tab[m][n_wr[m]] = a;
    wd_tab[m][n_wr[m]] = d;
    n_wr[m]++;
  endtask

  task automatic wait_done(input string tag, input int budget);
    logic done;
    done = 1'b0;
    for (int i = 0; i < budget && !done; i++) begin
      @(posedge aclk);
      #2;
      done = (rd_idx[0] == n_rd[0]) && (rd_idx[1] == n_rd[1]) &&
             (wr_idx[0] == n_wr[0]) && (wr_idx[1] == n_wr[1]) && (grant == 2'b00);
    end
    check_val(tag, {31'd0, done}, 32'd1);
  endtask

  int base, b0, c0;
  logic hit;

  initial begin
    for (int gi = 0; gi < 2; gi++) begin
      n_rd[gi] = 0; n_wr[gi] = 0; rd_idx[gi] = 0; wr_idx[gi] = 0; b_cnt[gi] = 0; r_cyc[gi] = 0;
      rd_wait[gi] = 1'b0; aw_done[gi] = 1'b0; w_done[gi] = 1'b0;
    end

    // Reset held with both masters requesting reads
    areset_n = 1'b0;
    sl_rdata = 32'h1234_5678;
    push_rd(0, 12'h100);
    push_rd(1, 12'h104);
    repeat (3) @(negedge aclk);
    #3;
    check_val("rst_grant", {30'd0, grant}, 32'd0);
    check_val("rst_outputs", {31'd0, any_out()}, 32'd0);
    @(negedge aclk);
    areset_n = 1'b1;
    @(posedge aclk);
    #1;
    check_val("rel_grant", {30'd0, grant}, 32'd1);
    check_val("rel_arvalid", {31'd0, s_arvalid}, 32'd1);
    check_val("rel_araddr", {20'd0, s_araddr}, 32'h100);
    wait_done("rel_done", 40);
    check_val("rel_order0", {20'd0, lg_addr[0]}, 32'h100);
    check_val("rel_order1", {20'd0, lg_addr[1]}, 32'h104);
    check_val("rel_rdata", rdat_log[0][0], 32'h1234_5678);

    // Contention: 4 writes per master, strict alternation, 3-cycle AW spacing
    base = lg_n;
    for (int i = 0; i < 4; i++) begin
      push_wr(0, 12'h010, 32'hA0 + i);
      push_wr(1, 12'h020, 32'hB0 + i);
    end
    wait_done("cont_done", 200);
    for (int i = 0; i < 8; i++) begin
      check_val($sformatf("cont_order%0d", i), {19'd0, lg_wr[base+i], lg_addr[base+i]},
                (i % 2 == 0) ? 32'h1010 : 32'h1020);
      if (i > 0)
        check_val($sformatf("cont_gap%0d", i), lg_cyc[base+i] - lg_cyc[base+i-1], 32'd3);
    end
    check_val("cont_wdata0", lg_data[base], 32'hA0);
    check_val("cont_wdata1", lg_data[base+1], 32'hB0);
    check_val("cont_bcnt0", b_cnt[0], 32'd4);
    check_val("cont_bcnt1", b_cnt[1], 32'd4);

    // Single read with 3-cycle slave latency
    sl_rlat = 3;
    sl_rdata = 32'hDEAD_BEEF;
    base = lg_n;
    push_rd(0, 12'h004);
    wait_done("single_done", 40);
    check_val("single_addr", {19'd0, lg_wr[base], lg_addr[base]}, 32'h004);
    check_val("single_rdata", rdat_log[0][rd_idx[0]-1], 32'hDEAD_BEEF);
    check_val("single_rresp", {30'd0, rresp_log[0][rd_idx[0]-1]}, 32'd0);
    check_val("single_m1_reads", rd_idx[1], 32'd1);
    check_val("single_idle", {30'd0, grant}, 32'd0);

    // Mixed valids on m1 plus a competing m0 read; prio currently favours m1
    sl_rlat = 1;
    sl_rdata = 32'h5555_AAAA;
    base = lg_n;
    push_rd(1, 12'h030);
    push_wr(1, 12'h040, 32'hC0);
    push_rd(0, 12'h060);
    wait_done("mixed_done", 60);
    check_val("mixed_order0", {19'd0, lg_wr[base],   lg_addr[base]},   32'h0030);
    check_val("mixed_order1", {19'd0, lg_wr[base+1], lg_addr[base+1]}, 32'h0060);
    check_val("mixed_order2", {19'd0, lg_wr[base+2], lg_addr[base+2]}, 32'h1040);
    check_val("mixed_rdata", rdat_log[1][rd_idx[1]-1], 32'h5555_AAAA);

    // Mid-transaction reset: m0 read sets prio to m1, then an m0 write is cut short
    push_rd(0, 12'h070);
    wait_done("mrst_pre", 40);
    sl_blat = 6;
    push_wr(0, 12'h080, 32'hD0);
    hit = 1'b0;
    for (int i = 0; i < 20 && !hit; i++) begin
      @(posedge aclk);
      #2;
      hit = sl_aw_got;
    end
    check_val("mrst_in_wr", {31'd0, hit}, 32'd1);
    b0 = b_cnt[0];
    @(negedge aclk);
    #3;
    areset_n = 1'b0;
    m_abort = 1'b1;
    #1;
    check_val("mrst_grant", {30'd0, grant}, 32'd0);
    check_val("mrst_outputs", {31'd0, any_out()}, 32'd0);
    repeat (2) @(negedge aclk);
    m_abort = 1'b0;
    sl_blat = 0;
    @(posedge aclk);
    #2;
    areset_n = 1'b1;
    base = lg_n;
    push_rd(0, 12'hA00);
    push_rd(1, 12'hB00);
    @(negedge aclk);
    @(posedge aclk);
    #1;
    check_val("mrst_prio", {30'd0, grant}, 32'd1);
    wait_done("mrst_done", 40);
    check_val("mrst_no_bvalid", b_cnt[0], b0);
    check_val("mrst_order0", {20'd0, lg_addr[base]}, 32'hA00);
    check_val("mrst_order1", {20'd0, lg_addr[base+1]}, 32'hB00);

`ifdef AXI_ARB_TIMEOUT_EN
    // Watchdog: slave never accepts m0's AR; SLVERR after 8 RD cycles, then m1 is served
    sl_ar_en = 1'b0;
    base = lg_n;
    b0 = rd_idx[0];
    c0 = cyc;
    push_rd(0, 12'h0C0);
    push_rd(1, 12'h0D0);
    hit = 1'b0;
    for (int i = 0; i < 40 && !hit; i++) begin
      @(posedge aclk);
      #2;
      hit = (rd_idx[0] != b0);
    end
    check_val("to_fired", {31'd0, hit}, 32'd1);
    sl_ar_en = 1'b1;
    check_val("to_latency", r_cyc[0] - c0, 32'd10);
    check_val("to_rresp", {30'd0, rresp_log[0][b0]}, 32'd2);
    check_val("to_rdata", rdat_log[0][b0], 32'd0);
    wait_done("to_done", 40);
    check_val("to_m1_addr", {19'd0, lg_wr[base], lg_addr[base]}, 32'h00D0);
`endif

    check_val("isolation", viol, 32'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/axi_lite_arbiter.md
# axi_lite_arbiter

Two-master to one-slave AXI4-Lite arbiter for the axi4-lite-interconnect. It shares a single slave port between two single-outstanding AXI-Lite masters. Arbitration is transaction-granular round-robin: a granted master owns the slave from address phase through its R or B handshake. Reads and writes are fully serialized, with no overlap.

## Interface
Parameters:
- ADDR_W, 12, address width (matches addr_t)
- DATA_W, 32, data width; strobe width is DATA_W/8
- TIMEOUT, 64, watchdog limit in cycles; used only with AXI_ARB_TIMEOUT_EN

Ports (N ∈ {0,1}, one master port per N):
- aclk  input  1  clock; all logic on rising edge
- areset_n  input  1  asynchronous, active-low reset
- mN_araddr, mN_arvalid  input  ADDR_W, 1  master read address
- mN_arready  output  1  read address accept
- mN_rdata, mN_rresp, mN_rvalid  output  DATA_W, 2, 1  read data and response
- mN_rready  input  1  master ready for read data
- mN_awaddr, mN_awvalid  input  ADDR_W, 1  write address
- mN_awready  output  1  write address accept
- mN_wdata, mN_wstrb, mN_wvalid  input  DATA_W, DATA_W/8, 1  write data
- mN_wready  output  1  write data accept
- mN_bresp, mN_bvalid  output  2, 1  write response
- mN_bready  input  1  master ready for response
- s_araddr, s_arvalid, s_arready, s_rdata, s_rresp, s_rvalid, s_rready  slave read side; directions are the mirror of the mN_ ports
- s_awaddr, s_awvalid, s_awready, s_wdata, s_wstrb, s_wvalid, s_wready, s_bresp, s_bvalid, s_bready  slave write side; directions are the mirror of the mN_ ports
- grant  output  2  one-hot current owner; 2'b00 when idle

## Operation
- FSM states: IDLE, RD, WR (plus RD_ERR and WR_ERR, see Configuration).
- Registers: state, owner (1 bit), prio pointer (1 bit, the master favoured on a tie).
- Request of master N: mN_arvalid | mN_awvalid.
- IDLE, no request: stay in IDLE.
- IDLE, one master requesting: that master becomes owner.
- IDLE, both masters requesting: the master selected by prio becomes owner.
- Read/write choice for the new owner: if its arvalid is high, go to RD; otherwise go to WR. A read wins if the owner has both valids high.
- RD:
  - owner's AR is routed to s_ar*, and s_arready is returned to the owner;
  - s_r* is routed to the owner, and owner rready is routed to s_rready;
  - exit to IDLE on the s_rvalid & s_rready handshake.
- WR:
  - owner's AW, W and bready are routed to the slave;
  - s_awready, s_wready and s_b* are returned to the owner;
  - exit to IDLE on the s_bvalid & s_bready handshake.
- On every exit to IDLE: prio <= ~owner. This gives strict alternation under continuous contention.
- Non-owner master sees all its ready and valid outputs at 0, and its data and resp outputs at 0. Its valids stay pending and are never dropped.
- In IDLE:
  - all s_ valid and ready outputs are 0, and s_ address, data and strb outputs are 0;
  - all mN_ readies are 0.
- Addresses, data and strobes pass through unmodified. No decode is performed.

## Timing
- Reset: asserting areset_n low immediately (asynchronously) forces state=IDLE, prio=0 and owner=0. Every output is 0 while reset is held, including grant=2'b00.
- Reset asserted mid-transaction abandons the transaction. There is no completion to either side.
- Arbitration latency: a request sampled in IDLE at edge k gives grant valid and routing active from edge k+1. s_arvalid or s_awvalid asserts 1 cycle after the master's valid.
- Datapath routing is combinational on state and owner. There are zero added cycles per channel once granted.
- At least 1 IDLE cycle between consecutive transactions, even for the same master.
- A master holding awvalid and wvalid together: the W channel is forwarded in the same WR state. Its ordering relative to AW is left to the slave.
- A new request arriving during RD or WR has no effect until IDLE.

## Configuration
- Macro AXI_ARB_TIMEOUT_EN.
- Defined:
  - a counter (clog2(TIMEOUT+1) bits) clears on entry to RD or WR and increments each cycle in RD or WR;
  - on reaching TIMEOUT with no completing handshake, the FSM moves to RD_ERR or WR_ERR;
  - in RD_ERR and WR_ERR all s_ valids and readies are 0;
  - in RD_ERR the arbiter itself drives owner rvalid=1, rdata=0, rresp=2'b10 (SLVERR) until owner rready, then goes to IDLE;
  - in WR_ERR it drives bvalid=1, bresp=2'b10 until owner bready, then goes to IDLE;
  - prio updates as on a normal exit.
- Undefined: no counter, no ERR states. RD and WR wait indefinitely.

## Test plan
- Reset: hold areset_n=0 with both masters driving arvalid=1 -> all outputs 0 and grant=00. After release, grant=01 on the second edge.
- Single read: m0 araddr=12'h004; slave returns rdata=32'hDEADBEEF and rresp=00 after 3 cycles -> m0_rdata=32'hDEADBEEF, m1 sees nothing, FSM returns to IDLE.
- Contention: m0 and m1 each issue 4 back-to-back writes (awaddr 12'h010/12'h020) -> slave sees the order m0, m1, m0, m1, ..., with exactly 1 idle cycle between each.
- Mixed valids: m1 asserts arvalid and awvalid together -> the read completes first. The write is served on m1's next grant, after any pending m0 request.
- Mid-transaction reset: pulse areset_n low during WR, before the B handshake -> outputs go to 0 asynchronously, no bvalid reaches the master, and prio=0 afterwards.
- AXI_ARB_TIMEOUT_EN with TIMEOUT=8: slave never asserts arready -> after 8 cycles m0 receives rvalid=1, rresp=2'b10, rdata=0, then m1's pending request is granted.
